pixel_stream_receiver: RTL and testbench
========================================

Name: pixel_stream_receiver

Overview:
- AXI-Stream video sink: the receive end of the pixel generator's output stream (32-bit words, tuser = SOF, tlast = EOL).
- Generates tready with selectable backpressure and tracks word and line position.
- Detects and counts framing errors, resynchronises on them, and unpacks 3 words into 4 RGB pixels.
- Sits in front of downstream pixel consumers (frame buffer, on-chip checker) and is the synthesizable counterpart of the bench-side stream checker.

Parameters:
- X_SIZE, 768, words per line; must be a multiple of 3; pixels per line = X_SIZE*4/3.
- Y_SIZE, 768, lines per frame.
- READY_MODE, 1, tready policy: 1 = always ready, 2 = PRBS random, 3 = ready after valid.
- RND_SEED, 33'd1246505138, PRBS initial value.
- TIMEOUT, 10000, consecutive cycles of tvalid low in ACTIVE before a timeout error.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_stream_tdata  in  32  packed pixel bytes, little-endian
- in_stream_tkeep  in  4  ignored
- in_stream_tuser  in  1  start of frame
- in_stream_tlast  in  1  end of line
- in_stream_tvalid  in  1  word valid
- in_stream_tready  out  1  word accepted when tvalid & tready
- pix_valid  out  1  pixel strobe; no backpressure
- pix_data  out  24  pixel bytes: byte n at [8n+7:8n]
- pix_x  out  11  pixel column
- pix_y  out  11  line
- pix_sof  out  1  pixel (0,0)
- pix_eol  out  1  last pixel of line
- frame_count  out  32  accepted SOF words
- err_sof_missing, err_sof_unexpected, err_eol_missing, err_eol_unexpected, err_timeout  out  1 each  single-cycle error pulses
- err_count  out  16  total error pulses, saturating

Behaviour:
- Reset (clk edge with rst=1): all outputs 0, tready 0, state WAIT_SOF, x=y=phase=0, prbs=RND_SEED, pending=0.
- PRBS update every cycle: prbs <= {prbs[31:0], prbs[32] ^ ~prbs[19]}.
- ready_src, registered:
  - mode 1: 1.
  - mode 2: prbs[32].
  - mode 3: 0 if (tvalid & tready), else tvalid.
- tready = ready_src & ~pending. Accept = tvalid & tready.
- State WAIT_SOF:
  - Accept with tuser=1: frame_count++, word treated as x=0, y=0; go to ACTIVE.
  - Accept with tuser=0: word dropped, no pixel output, err_sof_missing pulse.
- State ACTIVE, per accepted word at position (x, y):
  - tuser=1 with (x,y) != (0,0): err_sof_unexpected; resync, word becomes (0,0) of a new frame; frame_count++; phase=0; pending cleared.
  - x == X_SIZE-1, tlast=1: line ends normally.
  - x == X_SIZE-1, tlast=0: err_eol_missing; line is still forced to end.
  - x < X_SIZE-1, tlast=1: err_eol_unexpected; x=0, y++, phase=0; any held bytes are discarded (no partial pixel output).
  - Line end on y == Y_SIZE-1: go to WAIT_SOF, y=0. Otherwise x=0, y++.
  - SOF and EOL errors on the same word: both pulses fire; SOF resync applies first, then the EOL rule.
- Unpacking (phase 0..2, reset at every line start). Registered: pix_* valid the cycle after accept.
  - Phase 0: pixel0 = w0[23:0]; hold w0[31:24].
  - Phase 1: pixel1 = {w1[15:0], held}; hold w1[31:16].
  - Phase 2: pixel2 = {w2[7:0], held}. pixel3 = w2[31:8] is emitted the following cycle (pending=1 forces tready low for exactly that cycle).
- pix_x increments per pixel and resets at line start. pix_sof=1 on pixel x=0, y=0. pix_eol=1 on pixel x=X_SIZE*4/3-1, and on the last emitted pixel of a line cut short by an unexpected EOL.
- Timeout: in ACTIVE, counter increments while tvalid=0 and clears on tvalid=1. On reaching TIMEOUT: err_timeout pulse, counter restarts. Counter is held at 0 in WAIT_SOF.
- err_count: +1 per pulsing signal per cycle (can add 2 in one cycle); saturates at 16'hFFFF.
- rst asserted mid-frame: the next cycle behaves exactly as after the initial reset.

Decomposition:
- Package pixel_stream_pkg:
  - READY_* mode constants.
  - state enum {WAIT_SOF, ACTIVE}.
  - PIX_W=24, COORD_W=11.
- Sub-module stream_ready_gen: PRBS and READY_MODE logic, outputs ready_src.
- Framing FSM and unpacker remain in the top module.

Test Plan:
- X_SIZE=6, Y_SIZE=2, mode 1, two clean frames -> frame_count=2, 8 pixels per line, pix_eol at x=7, pix_sof once per frame, no errors.
- Words 0x44332211, 0x88776655, 0xCCBBAA99 -> pixels 0x332211, 0x665544, 0x998877, then 0xCCBBAA one cycle later; tready=0 in that cycle.
- After reset, 3 words with tuser=0, then an SOF word -> three err_sof_missing pulses, no pix_valid before the SOF word's pixel, frame_count=1.
- tlast on word x=2 of line 0 -> err_eol_unexpected; next word is x=0, y=1; its pixel is w[23:0] (phase reset).
- No tlast on word x=5, then tuser mid-line on line 1 -> err_eol_missing then err_sof_unexpected; frame_count increments; err_count=2.
- Mode 2 with TIMEOUT=20, tvalid held low 45 cycles in ACTIVE -> exactly 2 err_timeout pulses; tready matches the reference PRBS sequence from RND_SEED.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared constants and types for the pixel stream receiver slice.
package pixel_stream_pkg;

  // tready policies selectable through READY_MODE
  localparam int READY_ALWAYS      = 1;
  localparam int READY_PRBS        = 2;
  localparam int READY_AFTER_VALID = 3;

  localparam int PIX_W   = 24;
  localparam int COORD_W = 11;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  // Number of asserted bits in an error pulse vector
  function automatic logic [2:0] countPulses(input logic [4:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pixel_stream_receiver_ready.sv
// Ready source for the receiver: fixed, PRBS-driven or handshake-paced.
module stream_ready_gen
  import pixel_stream_pkg::*;
#(
  parameter int          READY_MODE = READY_ALWAYS,
  parameter logic [32:0] RND_SEED   = 33'd1246505138
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tvalid,
  input  logic i_tready,
  output logic o_readySrc
);

  logic [32:0] r_prbs;
  logic        w_readyNext;

  // PRBS advances every cycle regardless of mode so the sequence stays predictable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prbs <= RND_SEED;
    end else begin
      r_prbs <= {r_prbs[31:0], r_prbs[32] ^ ~r_prbs[19]};
    end
  end

  // Next ready value for the selected policy
  always_comb begin
    w_readyNext = 1'b1;
    case (READY_MODE)
      READY_PRBS:        w_readyNext = r_prbs[32];
      READY_AFTER_VALID: w_readyNext = (i_tvalid & i_tready) ? 1'b0 : i_tvalid;
      default:           w_readyNext = 1'b1;
    endcase
  end

  // Ready source is registered so tready never depends combinationally on tvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      o_readySrc <= 1'b0;
    end else begin
      o_readySrc <= w_readyNext;
    end
  end

endmodule

// File: rtl/pixel_stream_receiver.sv
// AXI-Stream video sink: framing checks, resync and 3-word to 4-pixel unpacking.
module pixel_stream_receiver
  import pixel_stream_pkg::*;
#(
  parameter int          X_SIZE     = 768,
  parameter int          Y_SIZE     = 768,
  parameter int          READY_MODE = 1,
  parameter logic [32:0] RND_SEED   = 33'd1246505138,
  parameter int          TIMEOUT    = 10000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        in_stream_tdata,
  input  logic [3:0]         in_stream_tkeep,
  input  logic               in_stream_tuser,
  input  logic               in_stream_tlast,
  input  logic               in_stream_tvalid,
  output logic               in_stream_tready,
  output logic               pix_valid,
  output logic [PIX_W-1:0]   pix_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic [31:0]        frame_count,
  output logic               err_sof_missing,
  output logic               err_sof_unexpected,
  output logic               err_eol_missing,
  output logic               err_eol_unexpected,
  output logic               err_timeout,
  output logic [15:0]        err_count
);

  localparam int                 TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_SIZE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_SIZE - 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT - 1);

  state_t               r_state, w_stateNext;
  logic [COORD_W-1:0]   r_x, r_y, w_xNext, w_yNext, w_wordX, w_wordY, w_pixCol;
  logic [1:0]           r_phase, w_phaseNext, w_wordPhase;
  logic [15:0]          r_held;
  logic                 r_pending, r_pendEol;
  logic [PIX_W-1:0]     r_pendData;
  logic [COORD_W-1:0]   r_pendX, r_pendY, r_pixNext;
  logic [TO_W-1:0]      r_toCnt;
  logic                 w_readySrc, w_accept, w_take, w_lineEnd, w_frameInc;
  logic                 w_errSofMissing, w_errSofUnexp, w_errEolMissing, w_errEolUnexp, w_errTimeout;
  logic [2:0]           w_errSum;
  logic [16:0]          w_errCountSum;
  logic                 w_unusedKeep;

  assign w_unusedKeep     = ^in_stream_tkeep;
  assign in_stream_tready = w_readySrc & ~r_pending;
  assign w_accept         = in_stream_tvalid & in_stream_tready;

  stream_ready_gen #(
    .READY_MODE(READY_MODE),
    .RND_SEED  (RND_SEED)
  ) u_ready (
    .clk       (clk),
    .rst       (rst),
    .i_tvalid  (in_stream_tvalid),
    .i_tready  (in_stream_tready),
    .o_readySrc(w_readySrc)
  );

  // Framing decisions for the accepted word: resync first, then the end-of-line rule
  always_comb begin
    w_stateNext     = r_state;
    w_xNext         = r_x;
    w_yNext         = r_y;
    w_phaseNext     = r_phase;
    w_wordX         = r_x;
    w_wordY         = r_y;
    w_wordPhase     = r_phase;
    w_take          = 1'b0;
    w_lineEnd       = 1'b0;
    w_frameInc      = 1'b0;
    w_errSofMissing = 1'b0;
    w_errSofUnexp   = 1'b0;
    w_errEolMissing = 1'b0;
    w_errEolUnexp   = 1'b0;
    if (w_accept) begin
      if (r_state == WAIT_SOF) begin
        if (in_stream_tuser) begin
          w_take      = 1'b1;
          w_frameInc  = 1'b1;
          w_wordX     = '0;
          w_wordY     = '0;
          w_wordPhase = 2'd0;
        end else begin
          w_errSofMissing = 1'b1;
        end
      end else begin
        w_take = 1'b1;
        if (in_stream_tuser) begin
          w_frameInc    = 1'b1;
          w_errSofUnexp = (r_x != '0) || (r_y != '0);
          w_wordX       = '0;
          w_wordY       = '0;
          w_wordPhase   = 2'd0;
        end
      end
      if (w_take) begin
        if (w_wordX == X_LAST) begin
          w_lineEnd       = 1'b1;
          w_errEolMissing = ~in_stream_tlast;
        end else if (in_stream_tlast) begin
          w_lineEnd     = 1'b1;
          w_errEolUnexp = 1'b1;
        end
        w_stateNext = ACTIVE;
        if (w_lineEnd) begin
          w_xNext     = '0;
          w_phaseNext = 2'd0;
          if (w_wordY == Y_LAST) begin
            w_yNext     = '0;
            w_stateNext = WAIT_SOF;
          end else begin
            w_yNext = w_wordY + COORD_W'(1);
          end
        end else begin
          w_xNext     = w_wordX + COORD_W'(1);
          w_yNext     = w_wordY;
          w_phaseNext = (w_wordPhase == 2'd2) ? 2'd0 : w_wordPhase + 2'd1;
        end
      end
    end
    w_pixCol = (w_wordX == '0) ? '0 : r_pixNext;
  end

  assign w_errTimeout = (r_state == ACTIVE) && !in_stream_tvalid && (r_toCnt == TO_LAST);
  assign w_errSum     = countPulses({w_errTimeout, w_errEolUnexp, w_errEolMissing,
                                     w_errSofUnexp, w_errSofMissing});
  assign w_errCountSum = {1'b0, err_count} + {14'd0, w_errSum};

  // Framing state and word position register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_SOF;
      r_x     <= '0;
      r_y     <= '0;
      r_phase <= 2'd0;
    end else begin
      r_state <= w_stateNext;
      r_x     <= w_xNext;
      r_y     <= w_yNext;
      r_phase <= w_phaseNext;
    end
  end

  // Unpacker: one pixel per word plus a fourth pixel the cycle after a phase-2 word
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      r_held     <= '0;
      r_pending  <= 1'b0;
      r_pendData <= '0;
      r_pendX    <= '0;
      r_pendY    <= '0;
      r_pendEol  <= 1'b0;
      r_pixNext  <= '0;
    end else begin
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      if (w_take) begin
        pix_valid <= 1'b1;
        pix_x     <= w_pixCol;
        pix_y     <= w_wordY;
        pix_sof   <= (w_pixCol == '0) && (w_wordY == '0);
        case (w_wordPhase)
          2'd0: begin
            pix_data    <= in_stream_tdata[23:0];
            r_held[7:0] <= in_stream_tdata[31:24];
            pix_eol     <= w_lineEnd;
            r_pixNext   <= w_pixCol + COORD_W'(1);
          end
          2'd1: begin
            pix_data  <= {in_stream_tdata[15:0], r_held[7:0]};
            r_held    <= in_stream_tdata[31:16];
            pix_eol   <= w_lineEnd;
            r_pixNext <= w_pixCol + COORD_W'(1);
          end
          default: begin
            pix_data   <= {in_stream_tdata[7:0], r_held};
            r_pending  <= 1'b1;
            r_pendData <= in_stream_tdata[31:8];
            r_pendX    <= w_pixCol + COORD_W'(1);
            r_pendY    <= w_wordY;
            r_pendEol  <= w_lineEnd;
            r_pixNext  <= w_pixCol + COORD_W'(2);
          end
        endcase
      end else if (r_pending) begin
        pix_valid <= 1'b1;
        pix_data  <= r_pendData;
        pix_x     <= r_pendX;
        pix_y     <= r_pendY;
        pix_eol   <= r_pendEol;
        r_pending <= 1'b0;
      end
    end
  end

  // Idle watchdog: only meaningful while a frame is in progress
  always_ff @(posedge clk) begin
    if (rst || (r_state == WAIT_SOF) || in_stream_tvalid || w_errTimeout) begin
      r_toCnt <= '0;
    end else begin
      r_toCnt <= r_toCnt + TO_W'(1);
    end
  end

  // Frame counter, error pulses and the saturating error total
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count        <= '0;
      err_sof_missing    <= 1'b0;
      err_sof_unexpected <= 1'b0;
      err_eol_missing    <= 1'b0;
      err_eol_unexpected <= 1'b0;
      err_timeout        <= 1'b0;
      err_count          <= '0;
    end else begin
      frame_count        <= frame_count + {31'd0, w_frameInc};
      err_sof_missing    <= w_errSofMissing;
      err_sof_unexpected <= w_errSofUnexp;
      err_eol_missing    <= w_errEolMissing;
      err_eol_unexpected <= w_errEolUnexp;
      err_timeout        <= w_errTimeout;
      err_count          <= w_errCountSum[16] ? 16'hFFFF : w_errCountSum[15:0];
    end
  end

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Scoreboard bench: three receivers (one per ready policy) share one stimulus path.
module tb_pixel_stream_receiver;

  localparam int          X    = 6;
  localparam int          Y    = 2;
  localparam int          TO   = 20;
  localparam logic [32:0] SEED = 33'd1246505138;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tuser, tlast, tvalid;
  logic [1:0]  sel;

  logic        tv[3], trdy[3], pv[3], psof[3], peol[3];
  logic [23:0] pd[3];
  logic [10:0] px[3], py[3];
  logic [31:0] fc[3];
  logic [15:0] ec[3];
  logic        eSofM[3], eSofU[3], eEolM[3], eEolU[3], eTo[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    assign tv[g] = tvalid & (sel == 2'(g));
    pixel_stream_receiver #(
      .X_SIZE(X), .Y_SIZE(Y), .READY_MODE(g + 1), .RND_SEED(SEED), .TIMEOUT(TO)
    ) dut (
      .clk(clk), .rst(rst),
      .in_stream_tdata(tdata), .in_stream_tkeep(tkeep),
      .in_stream_tuser(tuser), .in_stream_tlast(tlast),
      .in_stream_tvalid(tv[g]), .in_stream_tready(trdy[g]),
      .pix_valid(pv[g]), .pix_data(pd[g]), .pix_x(px[g]), .pix_y(py[g]),
      .pix_sof(psof[g]), .pix_eol(peol[g]), .frame_count(fc[g]),
      .err_sof_missing(eSofM[g]), .err_sof_unexpected(eSofU[g]),
      .err_eol_missing(eEolM[g]), .err_eol_unexpected(eEolU[g]),
      .err_timeout(eTo[g]), .err_count(ec[g])
    );
  end

  logic        tready_m, pv_m;
  logic [47:0] pix_m;
  logic [31:0] fc_m;
  logic [15:0] ec_m;
  logic [4:0]  err_m;
  assign tready_m = trdy[sel];
  assign pv_m     = pv[sel];
  assign pix_m    = {pd[sel], px[sel], py[sel], psof[sel], peol[sel]};
  assign fc_m     = fc[sel];
  assign ec_m     = ec[sel];
  assign err_m    = {eTo[sel], eEolU[sel], eEolM[sel], eSofU[sel], eSofM[sel]};

  typedef struct {
    logic [23:0] data;
    int          x;
    int          y;
    bit          sof;
    bit          eol;
  } pix_t;

  pix_t        expQ[$];
  logic [4:0]  errQ[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state: word position, pending byte stream, pixel column
  bit          mActive;
  int          mx, my, mCol, mFrames, mErrs, mIdle;
  logic [7:0]  bq[$];

  // Reference ready sequence for the PRBS policy
  logic [32:0] refPrbs;
  logic        refRdy;
  always @(posedge clk) begin
    if (rst) begin
      refPrbs <= SEED;
      refRdy  <= 1'b0;
    end else begin
      refRdy  <= refPrbs[32];
      refPrbs <= {refPrbs[31:0], refPrbs[32] ^ ~refPrbs[19]};
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel or an error pulse
  always @(negedge clk) begin
    pix_t e;
    if (pv_m) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pixel_extra: got 0x%0h, expected no pixel", pix_m);
      end else begin
        e = expQ.pop_front();
        checkOutput("pixel", 64'(pix_m), 64'({e.data, 11'(e.x), 11'(e.y), e.sof, e.eol}));
      end
    end
    if (err_m != 5'd0) begin
      if (errQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL err_extra: got 0x%0h, expected no pulse", err_m);
      end else begin
        checkOutput("err_pulses", 64'(err_m), 64'(errQ.pop_front()));
      end
    end
  end

  // Model of one accepted word: framing rules plus byte-stream unpacking
  task automatic modelAccept(input logic [31:0] d, input bit u, input bit l);
    logic [4:0] eb;
    pix_t       p;
    pix_t       np[$];
    bit         lineEnd;
    eb = 5'd0;
    if (!mActive) begin
      if (!u) begin
        errQ.push_back(5'b00001);
        mErrs++;
        return;
      end
      mActive = 1;
      mFrames++;
      mx = 0; my = 0; mCol = 0;
      bq.delete();
    end else if (u) begin
      if (mx != 0 || my != 0) eb[1] = 1'b1;
      mFrames++;
      mx = 0; my = 0; mCol = 0;
      bq.delete();
    end
    for (int b = 0; b < 4; b++) bq.push_back(d[8*b +: 8]);
    while (bq.size() >= 3) begin
      p.data = {bq[2], bq[1], bq[0]};
      void'(bq.pop_front()); void'(bq.pop_front()); void'(bq.pop_front());
      p.x = mCol; p.y = my; p.sof = (mCol == 0 && my == 0); p.eol = 0;
      mCol++;
      np.push_back(p);
    end
    lineEnd = 0;
    if (mx == X - 1) begin
      lineEnd = 1;
      if (!l) eb[2] = 1'b1;
    end else if (l) begin
      lineEnd = 1;
      eb[3] = 1'b1;
    end
    np[np.size() - 1].eol = lineEnd;
    foreach (np[i]) expQ.push_back(np[i]);
    if (lineEnd) begin
      bq.delete();
      mCol = 0; mx = 0;
      if (my == Y - 1) begin
        my = 0;
        mActive = 0;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
    if (eb != 5'd0) begin
      errQ.push_back(eb);
      mErrs += $countones(eb);
    end
  endtask

  // Offer one word and hold it until the selected receiver accepts it
  task automatic applyStimulus(input logic [31:0] d, input bit u, input bit l);
    bit done;
    done   = 0;
    tdata  = d;
    tuser  = u;
    tlast  = l;
    tkeep  = 4'($urandom);
    tvalid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      mIdle = 0;
      if (tready_m) begin
        modelAccept(d, u, l);
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake: got no tready in 64 cycles, expected an accept");
      tvalid = 1'b0;
    end
  endtask

  // Idle cycles with tvalid low; the model tracks the watchdog and the PRBS ready
  task automatic idle(input int n, input bit checkRdy);
    tvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (mActive) begin
        mIdle++;
        if (mIdle == TO) begin
          errQ.push_back(5'b10000);
          mErrs++;
          mIdle = 0;
        end
      end else begin
        mIdle = 0;
      end
      @(negedge clk);
      if (checkRdy && i >= 2) checkOutput("tready_prbs", 64'(tready_m), 64'(refRdy));
    end
  endtask

  task automatic doReset(input logic [1:0] s);
    tvalid = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sel = s;
    checkOutput("reset_tready", 64'(tready_m), 64'd0);
    checkOutput("reset_pix_valid", 64'(pv_m), 64'd0);
    checkOutput("reset_frame_count", 64'(fc_m), 64'd0);
    checkOutput("reset_err_count", 64'(ec_m), 64'd0);
    checkOutput("reset_err_pulses", 64'(err_m), 64'd0);
    expQ.delete();
    errQ.delete();
    bq.delete();
    mActive = 0; mx = 0; my = 0; mCol = 0; mFrames = 0; mErrs = 0; mIdle = 0;
    rst = 1'b0;
  endtask

  task automatic checkpoint(input string tag);
    idle(4, 0);
    checkOutput({tag, "_pixels_drained"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, "_errors_drained"}, 64'(errQ.size()), 64'd0);
    checkOutput({tag, "_frame_count"}, 64'(fc_m), 64'(mFrames));
    checkOutput({tag, "_err_count"}, 64'(ec_m), 64'(mErrs));
  endtask

  task automatic sendFrame(input int pct, input int gapMax);
    bit u, l;
    for (int yy = 0; yy < Y; yy++) begin
      for (int xx = 0; xx < X; xx++) begin
        u = (xx == 0 && yy == 0);
        l = (xx == X - 1);
        if ($urandom_range(0, 99) < pct) u = ~u;
        if ($urandom_range(0, 99) < pct) l = ~l;
        applyStimulus($urandom, u, l);
        if (gapMax > 0) idle($urandom_range(0, gapMax), 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0; tuser = 0; tlast = 0; sel = 2'd0;

    // Always-ready: directed unpacking words, pending cycle, then clean frames
    doReset(2'd0);
    applyStimulus(32'h44332211, 1, 0);
    applyStimulus(32'h88776655, 0, 0);
    applyStimulus(32'hCCBBAA99, 0, 0);
    checkOutput("tready_pending", 64'(tready_m), 64'd0);
    idle(1, 0);
    checkOutput("tready_after_pending", 64'(tready_m), 64'd1);
    for (int xx = 3; xx < X; xx++) applyStimulus($urandom, 0, xx == X - 1);
    for (int xx = 0; xx < X; xx++) applyStimulus($urandom, 0, xx == X - 1);
    sendFrame(0, 0);
    checkpoint("clean");
    checkOutput("clean_frames_two", 64'(fc_m), 64'd2);

    // Missing SOF words are dropped, then an early EOL on line 0
    doReset(2'd0);
    repeat (3) applyStimulus($urandom, 0, 0);
    applyStimulus($urandom, 1, 0);
    applyStimulus($urandom, 0, 0);
    applyStimulus($urandom, 0, 1);
    for (int xx = 0; xx < X; xx++) applyStimulus($urandom, 0, xx == X - 1);
    checkpoint("sof_missing");
    checkOutput("sof_missing_frames", 64'(fc_m), 64'd1);

    // Missing EOL on line 0, then SOF mid-line on line 1 resyncs
    doReset(2'd0);
    for (int xx = 0; xx < X; xx++) applyStimulus($urandom, xx == 0, 0);
    for (int xx = 0; xx < 3; xx++) applyStimulus($urandom, 0, 0);
    applyStimulus($urandom, 1, 0);
    for (int xx = 1; xx < X; xx++) applyStimulus($urandom, 0, xx == X - 1);
    for (int xx = 0; xx < X; xx++) applyStimulus($urandom, 0, xx == X - 1);
    checkpoint("resync");
    checkOutput("resync_err_count", 64'(ec_m), 64'd2);

    // PRBS ready: stall mid-line long enough for two watchdog pulses
    doReset(2'd1);
    for (int xx = 0; xx < 3; xx++) applyStimulus($urandom, xx == 0, 0);
    idle(45, 1);
    for (int xx = 3; xx < X; xx++) applyStimulus($urandom, 0, xx == X - 1);
    for (int xx = 0; xx < X; xx++) applyStimulus($urandom, 0, xx == X - 1);
    checkpoint("timeout");

    // Randomized traffic with occasional framing faults under every ready policy
    for (int s = 0; s < 3; s++) begin
      doReset(2'(s));
      repeat (5) sendFrame(12, 3);
      checkpoint("random");
    end

    // Reset in the middle of a frame behaves like a fresh start
    doReset(2'd0);
    for (int xx = 0; xx < 4; xx++) applyStimulus($urandom, xx == 0, 0);
    idle(3, 0);
    doReset(2'd0);
    sendFrame(0, 1);
    checkpoint("midreset");
    checkOutput("midreset_frames", 64'(fc_m), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
